// File: rtl/fpu_sequencer.sv
// Sequencer that stalls the pipeline around a multi-cycle FPU operation and
// times the write-back capture. Optional watchdog enabled by FPU_TIMEOUT_EN.
module fpu_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fp_op_e,
    input  logic [4:0] fp_funct_e,
    input  logic       flush_e,
    input  logic       fpu_done,
    output logic       fpu_start,
    output logic [4:0] fpu_op,
    output logic       stall_fde,
    output logic       bubble_m,
    output logic       fp_wb_valid,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t     state_r;
    logic [4:0] fpu_op_r;
    logic       issue_s;
    logic       timeout_hit_s;

    // An FP instruction is only issued if it is not being flushed this cycle.
    assign issue_s = fp_op_e & ~flush_e;

`ifdef FPU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wdog_r;
    logic          timeout_err_r;

    // Watchdog expiry: the counter is on its last allowed cycle and nothing
    // else (flush, completion) moves the FSM out of the waiting state.
    always_comb begin
        timeout_hit_s = 1'b0;
        if (state_r == WAIT) begin
            timeout_hit_s = ~flush_e & ~fpu_done & (wdog_r == CNT_LAST);
        end else if (state_r == DRAIN) begin
            timeout_hit_s = ~fpu_done & (wdog_r == CNT_LAST);
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Watchdog counter restarts on every entry to WAIT or DRAIN; error is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_r        <= {CW{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            if ((state_r == START) || ((state_r == WAIT) && flush_e)) begin
                wdog_r <= {CW{1'b0}};
            end else if ((state_r == WAIT) || (state_r == DRAIN)) begin
                wdog_r <= wdog_r + CW'(1);
            end else begin
                wdog_r <= wdog_r;
            end
            if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    // TIMEOUT only matters when the watchdog is built.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end

    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Control FSM; fpu_op is captured only on an IDLE-state issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            fpu_op_r <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        fpu_op_r <= fp_funct_e;
                        state_r  <= START;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                START: begin
                    if (flush_e) begin
                        state_r <= DRAIN;
                    end else if (fpu_done) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush_e) begin
                        state_r <= DRAIN;
                    end else if (fpu_done) begin
                        state_r <= DONE;
                    end else if (timeout_hit_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                DRAIN: begin
                    if (fpu_done || timeout_hit_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register; all forced low while reset is held.
    always_comb begin
        fpu_start   = 1'b0;
        fp_wb_valid = 1'b0;
        busy        = 1'b0;
        stall_fde   = 1'b0;
        if (!reset) begin
            fpu_start   = (state_r == START);
            fp_wb_valid = (state_r == DONE);
            busy        = (state_r != IDLE);
            case (state_r)
                IDLE:    stall_fde = issue_s;
                START:   stall_fde = 1'b1;
                WAIT:    stall_fde = 1'b1;
                DRAIN:   stall_fde = 1'b1;
                DONE:    stall_fde = 1'b0;
                default: stall_fde = 1'b0;
            endcase
        end else begin
            fpu_start   = 1'b0;
            fp_wb_valid = 1'b0;
            busy        = 1'b0;
            stall_fde   = 1'b0;
        end
    end

    assign bubble_m = stall_fde;
    assign fpu_op   = fpu_op_r;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer: expected start/write-back pulses are
// queued at issue and matched by a negedge monitor; level checks are inline.
module tb_fpu_sequencer;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       fp_op_e;
    logic [4:0] fp_funct_e;
    logic       flush_e;
    logic       fpu_done;
    logic       fpu_start;
    logic [4:0] fpu_op;
    logic       stall_fde;
    logic       bubble_m;
    logic       fp_wb_valid;
    logic       busy;
    logic       timeout_err;

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit         is_wb;
        logic [4:0] op;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    fpu_sequencer #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .fp_op_e     (fp_op_e),
        .fp_funct_e  (fp_funct_e),
        .flush_e     (flush_e),
        .fpu_done    (fpu_done),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .stall_fde   (stall_fde),
        .bubble_m    (bubble_m),
        .fp_wb_valid (fp_wb_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Monitor: every start or write-back pulse must match the head of the queue.
    always @(negedge clk) begin
        if (fpu_start === 1'b1 || fp_wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, fpu_start, fp_wb_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk(mon_e.is_wb ? "wb_pulse_kind" : "start_pulse_kind",
                    {30'd0, fpu_start, fp_wb_valid}, mon_e.is_wb ? 32'd1 : 32'd2);
                chk(mon_e.is_wb ? "wb_pulse_cycle" : "start_pulse_cycle", cyc, mon_e.at);
                if (!mon_e.is_wb) chk("start_op", {27'd0, fpu_op}, {27'd0, mon_e.op});
            end
        end
    end

    // Issue one FP op in the current (IDLE) cycle; FPU answers n cycles after start.
    task automatic run_op(input logic [4:0] f, input int n);
        int c0;
        fp_op_e    = 1'b1;
        fp_funct_e = f;
        flush_e    = 1'b0;
        fpu_done   = 1'b0;
        c0 = cyc;
        exp_q.push_back('{is_wb: 1'b0, op: f, at: c0 + 1});
        exp_q.push_back('{is_wb: 1'b1, op: f, at: c0 + n + 2});
        neg();
        chk("issue_stall", {31'd0, stall_fde}, 32'd1);
        chk("issue_bubble", {31'd0, bubble_m}, 32'd1);
        for (int i = 1; i <= n; i++) begin
            nxt();
            fpu_done = 1'b0;
            neg();
            chk("run_stall", {31'd0, stall_fde}, 32'd1);
            chk("run_busy", {31'd0, busy}, 32'd1);
        end
        nxt();
        fpu_done = 1'b1;
        neg();
        chk("done_cycle_stall", {31'd0, stall_fde}, 32'd1);
        nxt();
        fpu_done = 1'b0;
        neg();
        chk("done_state_stall", {31'd0, stall_fde}, 32'd0);
        chk("done_state_busy", {31'd0, busy}, 32'd1);
        chk("done_state_op", {27'd0, fpu_op}, {27'd0, f});
    endtask

    initial begin
        int c0;
        reset      = 1'b1;
        fp_op_e    = 1'b1;
        fp_funct_e = 5'h1f;
        flush_e    = 1'b0;
        fpu_done   = 1'b1;

        // Reset held with an FP op and done present: everything stays quiet.
        nxt();
        neg();
        chk("rst_stall", {31'd0, stall_fde}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, fpu_start}, 32'd0);
        chk("rst_wb", {31'd0, fp_wb_valid}, 32'd0);
        chk("rst_op", {27'd0, fpu_op}, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        nxt();
        reset    = 1'b0;
        fp_op_e  = 1'b0;
        fpu_done = 1'b0;
        neg();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Stray fpu_done in IDLE is ignored.
        nxt();
        fpu_done = 1'b1;
        nxt();
        fpu_done = 1'b0;
        neg();
        chk("idle_done_ignored", {31'd0, busy}, 32'd0);

        // Single op, N=3.
        nxt();
        run_op(5'b00000, 3);
        nxt();
        fp_op_e = 1'b0;
        neg();
        chk("after_op_busy", {31'd0, busy}, 32'd0);
        chk("after_op_op", {27'd0, fpu_op}, 32'd0);

        // FP op flushed in IDLE: no issue.
        nxt();
        fp_op_e    = 1'b1;
        flush_e    = 1'b1;
        fp_funct_e = 5'b10101;
        neg();
        chk("flush_idle_stall", {31'd0, stall_fde}, 32'd0);
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);
        nxt();
        fp_op_e = 1'b0;
        flush_e = 1'b0;
        neg();
        chk("flush_idle_next_busy", {31'd0, busy}, 32'd0);
        chk("flush_idle_op_kept", {27'd0, fpu_op}, 32'd0);

        // Back-to-back ops, N=1.
        nxt();
        run_op(5'b00001, 1);
        nxt();
        run_op(5'b00011, 1);
        nxt();
        fp_op_e = 1'b0;
        neg();
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
        chk("b2b_op_held", {27'd0, fpu_op}, 32'd3);

        // Flush during WAIT: drain until fpu_done, no write-back.
        nxt();
        fp_op_e    = 1'b1;
        fp_funct_e = 5'b00111;
        c0 = cyc;
        exp_q.push_back('{is_wb: 1'b0, op: 5'b00111, at: c0 + 1});
        nxt();
        nxt();
        flush_e = 1'b1;
        fp_op_e = 1'b0;
        neg();
        chk("wait_flush_stall", {31'd0, stall_fde}, 32'd1);
        nxt();
        flush_e = 1'b0;
        neg();
        chk("drain_stall", {31'd0, stall_fde}, 32'd1);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        nxt();
        fpu_done = 1'b1;
        neg();
        chk("drain_done_stall", {31'd0, stall_fde}, 32'd1);
        nxt();
        fpu_done = 1'b0;
        neg();
        chk("drain_exit_busy", {31'd0, busy}, 32'd0);
        chk("drain_exit_stall", {31'd0, stall_fde}, 32'd0);

        // Reset during WAIT abandons the op; later fpu_done ignored.
        nxt();
        fp_op_e    = 1'b1;
        fp_funct_e = 5'b01001;
        c0 = cyc;
        exp_q.push_back('{is_wb: 1'b0, op: 5'b01001, at: c0 + 1});
        nxt();
        nxt();
        neg();
        chk("pre_rst_wait_busy", {31'd0, busy}, 32'd1);
        nxt();
        reset = 1'b1;
        neg();
        chk("midrst_stall", {31'd0, stall_fde}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        nxt();
        reset   = 1'b0;
        fp_op_e = 1'b0;
        neg();
        chk("postrst_busy", {31'd0, busy}, 32'd0);
        chk("postrst_stall", {31'd0, stall_fde}, 32'd0);
        chk("postrst_op", {27'd0, fpu_op}, 32'd0);
        nxt();
        fpu_done = 1'b1;
        nxt();
        fpu_done = 1'b0;
        neg();
        chk("postrst_done_ignored", {31'd0, busy}, 32'd0);

`ifdef FPU_TIMEOUT_EN
        // Watchdog: FPU never answers.
        nxt();
        fp_op_e    = 1'b1;
        fp_funct_e = 5'b00010;
        c0 = cyc;
        exp_q.push_back('{is_wb: 1'b0, op: 5'b00010, at: c0 + 1});
        nxt();
        fp_op_e = 1'b0;
        repeat (TO) nxt();
        neg();
        chk("wdog_last_wait_terr", {31'd0, timeout_err}, 32'd0);
        chk("wdog_last_wait_busy", {31'd0, busy}, 32'd1);
        nxt();
        neg();
        chk("wdog_terr", {31'd0, timeout_err}, 32'd1);
        chk("wdog_busy", {31'd0, busy}, 32'd0);
        chk("wdog_stall", {31'd0, stall_fde}, 32'd0);
        repeat (3) nxt();
        neg();
        chk("wdog_terr_sticky", {31'd0, timeout_err}, 32'd1);
        nxt();
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        neg();
        chk("wdog_terr_cleared", {31'd0, timeout_err}, 32'd0);
`else
        neg();
        chk("terr_tied_low", {31'd0, timeout_err}, 32'd0);
`endif

        nxt();
        nxt();
        neg();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
